// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB manager: FSM state encoding,
// protection bundle and index-width sizing.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Bit order matches pprot[2:0] = {instruction, nonsecure, privileged}.
  typedef struct packed {
    logic instruction;
    logic nonsecure;
    logic privileged;
  } apb_prot_t;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a byte address onto one of PrphNum contiguous 2^RegionBits regions
// starting at BaseAddr; hit is low below the base or past the last region.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int                   AddrWidth  = 32,
  parameter int                   PrphNum    = 4,
  parameter logic [AddrWidth-1:0] BaseAddr   = '0,
  parameter int                   RegionBits = 12,
  localparam int                  IdxWidth   = idx_width(PrphNum)
) (
  input  logic [AddrWidth-1:0] addr,
  output logic [IdxWidth-1:0]  idx,
  output logic [PrphNum-1:0]   sel,
  output logic                 hit
);

  logic [AddrWidth-1:0] region;

  always_comb begin
    region = (addr - BaseAddr) >> RegionBits;
    hit    = (addr >= BaseAddr) && (region < AddrWidth'(PrphNum));
    idx    = region[IdxWidth-1:0];
    sel    = hit ? (PrphNum'(1) << idx) : '0;
  end

endmodule

// File: rtl/apb_manager.sv
// Valid/ready request stream to APB bridge with address decode, per-lane
// response muxing and an ACCESS-phase watchdog.
//
// state  | meaning
// IDLE   | waiting for a request; req_ready high
// SETUP  | psel asserted, penable low, one cycle
// ACCESS | penable high, waiting for the selected pready or watchdog
// RESP   | response held on rsp_* until rsp_ready
module apb_manager
  import apb_pkg::*;
#(
  parameter int                   AddrWidth     = 32,
  parameter int                   DataWidth     = 32,
  parameter int                   PrphNum       = 4,
  parameter logic [AddrWidth-1:0] BaseAddr      = '0,
  parameter int                   RegionBits    = 12,
  parameter int                   TimeoutCycles = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [AddrWidth-1:0]           req_addr,
  input  logic                           req_write,
  input  logic [DataWidth-1:0]           req_wdata,
  input  logic [DataWidth/8-1:0]         req_strb,
  input  logic [2:0]                     req_prot,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DataWidth-1:0]           rsp_rdata,
  output logic                           rsp_error,
  output logic                           rsp_timeout,
  output logic [AddrWidth-1:0]           paddr,
  output logic [2:0]                     pprot,
  output logic [PrphNum-1:0]             psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [DataWidth-1:0]           pwdata,
  output logic [DataWidth/8-1:0]         pstrb,
  input  logic [PrphNum-1:0]             pready,
  input  logic [PrphNum*DataWidth-1:0]   prdata,
  input  logic [PrphNum-1:0]             pslverr
);

  localparam int IdxWidth  = idx_width(PrphNum);
  localparam int StrbWidth = DataWidth / 8;
  localparam int CntWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  apb_state_e           state_q, state_d;
  logic                 ready_q, ready_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0] strb_q, strb_d;
  apb_prot_t            prot_q, prot_d;
  logic [IdxWidth-1:0]  idx_q, idx_d;
  logic [PrphNum-1:0]   sel_q, sel_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 error_q, error_d;
  logic                 timeout_q, timeout_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;

  logic [IdxWidth-1:0]  dec_idx;
  logic [PrphNum-1:0]   dec_sel;
  logic                 dec_hit;
  logic                 lane_ready, lane_err, wd_expired;
  logic [DataWidth-1:0] lane_rdata;

  apb_addr_decoder #(
    .AddrWidth (AddrWidth),
    .PrphNum   (PrphNum),
    .BaseAddr  (BaseAddr),
    .RegionBits(RegionBits)
  ) u_dec (
    .addr(req_addr),
    .idx (dec_idx),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  // Only the registered index steers the lane mux; other lanes are don't-care.
  always_comb begin
    lane_ready = 1'b0;
    lane_err   = 1'b0;
    lane_rdata = '0;
    for (int i = 0; i < PrphNum; i++) begin
      if (idx_q == IdxWidth'(i)) begin
        lane_ready = pready[i];
        lane_err   = pslverr[i];
        lane_rdata = prdata[i*DataWidth +: DataWidth];
      end
    end
  end

  assign wd_expired = (TimeoutCycles != 0) && (cnt_q == CntWidth'(TimeoutCycles));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          addr_d    = req_addr;
          write_d   = req_write;
          wdata_d   = req_wdata;
          strb_d    = req_strb;
          prot_d    = apb_prot_t'(req_prot);
          idx_d     = dec_idx;
          sel_d     = dec_sel;
          rdata_d   = '0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          error_d   = !dec_hit;
          state_d   = dec_hit ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP: begin
        cnt_d   = CntWidth'(1);
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (lane_ready) begin
          error_d = lane_err;
          rdata_d = (!write_q && !lane_err) ? lane_rdata : '0;
          state_d = ST_RESP;
        end else if (wd_expired) begin
          error_d   = 1'b1;
          timeout_d = 1'b1;
          rdata_d   = '0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      idx_q     <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  logic apb_active;
  assign apb_active  = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

  assign req_ready   = ready_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_error   = error_q;
  assign rsp_timeout = timeout_q;
  assign paddr       = addr_q;
  assign pprot       = prot_q;
  assign pwrite      = write_q;
  assign pwdata      = wdata_q;
  assign psel        = apb_active ? sel_q : '0;
  assign penable     = (state_q == ST_ACCESS);
  assign pstrb       = (apb_active && write_q) ? strb_q : '0;

endmodule

// File: tb/tb_apb_manager.sv
// Bench for apb_manager: vector table of transfers with a response
// scoreboard, plus a reset-abort sequence.
module tb_apb_manager;

  logic         clk;
  logic         reset;
  logic         req_valid, req_ready;
  logic [31:0]  req_addr;
  logic         req_write;
  logic [31:0]  req_wdata;
  logic [3:0]   req_strb;
  logic [2:0]   req_prot;
  logic         rsp_valid, rsp_ready;
  logic [31:0]  rsp_rdata;
  logic         rsp_error, rsp_timeout;
  logic [31:0]  paddr;
  logic [2:0]   pprot;
  logic [3:0]   psel;
  logic         penable, pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [3:0]   pready;
  logic [127:0] prdata;
  logic [3:0]   pslverr;

  apb_manager #(
    .AddrWidth(32), .DataWidth(32), .PrphNum(4), .BaseAddr(32'h0),
    .RegionBits(12), .TimeoutCycles(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          ws;
    logic [31:0] lane_data;
    logic        slverr;
    int          bp;
    logic [3:0]  exp_psel;
    logic [3:0]  exp_pstrb;
    int          exp_cycle;
    logic        exp_error;
    logic        exp_timeout;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        error;
    logic        timeout;
  } rsp_t;

  vec_t vecs[9];
  rsp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur_vec = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %0h expected %0h", cur_vec, name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise_lanes(input int sel_i);
    pready  = 4'($urandom);
    pslverr = 4'($urandom);
    for (int i = 0; i < 4; i++) prdata[i*32 +: 32] = $urandom;
    if (sel_i >= 0) pready[sel_i] = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    check("req_ready_wait", req_ready, 1);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    rsp_t e;
    int   cyc, n_sel, n_en, hold, sel_i, exp_en;
    bit   done, got;
    v = vecs[k];
    cur_vec = k;
    sel_i = -1;
    for (int i = 0; i < 4; i++) if (v.exp_psel[i]) sel_i = i;
    exp_en = (v.exp_psel == 0) ? 0 : v.exp_cycle - 2;
    e = '{rdata: 32'h0, error: 1'b0, timeout: 1'b0};
    wait_ready();
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_write = v.write;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    req_prot  = v.prot;
    noise_lanes(sel_i);
    sb.push_back('{rdata: v.exp_rdata, error: v.exp_error, timeout: v.exp_timeout});
    step();
    // Scramble the request inputs so only registered copies can reach the bus.
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_write = ~v.write;
    req_wdata = $urandom;
    req_strb  = 4'($urandom);
    req_prot  = 3'($urandom);
    cyc = 1; n_sel = 0; n_en = 0; hold = 0; done = 0; got = 0;
    while (!done && cyc < 40) begin
      noise_lanes(sel_i);
      check("req_ready_busy", req_ready, 0);
      if (psel != 0) begin
        n_sel++;
        check("psel", psel, v.exp_psel);
        check("pstrb", pstrb, v.exp_pstrb);
        check("paddr", paddr, v.addr);
        check("pwrite", pwrite, v.write);
        check("pwdata", pwdata, v.wdata);
        check("pprot", pprot, v.prot);
      end
      if (penable) begin
        n_en++;
        if (n_en > v.ws && sel_i >= 0) begin
          pready[sel_i]           = 1'b1;
          pslverr[sel_i]          = v.slverr;
          prdata[sel_i*32 +: 32]  = v.lane_data;
        end
      end
      if (rsp_valid) begin
        if (!got) begin
          got = 1;
          if (sb.size() > 0) e = sb.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(v.exp_cycle));
          check("access_cycles", 64'(n_en), 64'(exp_en));
          check("setup_access_cycles", 64'(n_sel), 64'((exp_en == 0) ? 0 : exp_en + 1));
        end
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_error", rsp_error, e.error);
        check("rsp_timeout", rsp_timeout, e.timeout);
        check("resp_bus_idle", {psel, penable, pstrb}, 0);
        if (hold >= v.bp) begin
          rsp_ready = 1'b1;
          done = 1;
        end else begin
          hold++;
        end
      end
      step();
      cyc++;
    end
    rsp_ready = 1'b0;
    check("rsp_arrived", done, 1);
    if (!got && sb.size() > 0) void'(sb.pop_front());
    check("rsp_valid_drop", rsp_valid, 0);
    check("req_ready_return", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit bad;
    //           addr          wr    wdata         strb     prot    ws   lane_data     err   bp  psel     pstrb    cyc err to   rdata
    vecs[0] = '{32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'b1111, 3'b000, 0,   32'h1111_1111, 1'b0, 0, 4'b0010, 4'b1111, 3,  1'b0, 1'b0, 32'h0};
    vecs[1] = '{32'h0000_3010, 1'b0, 32'hA5A5_0001, 4'b1111, 3'b010, 3,   32'h1234_5678, 1'b0, 0, 4'b1000, 4'b0000, 6,  1'b0, 1'b0, 32'h1234_5678};
    vecs[2] = '{32'h0000_4000, 1'b0, 32'h0,         4'b1111, 3'b000, 0,   32'h0,         1'b0, 0, 4'b0000, 4'b0000, 1,  1'b1, 1'b0, 32'h0};
    vecs[3] = '{32'h0000_0008, 1'b0, 32'h0BAD_0003, 4'b0011, 3'b001, 100, 32'h7777_7777, 1'b0, 0, 4'b0001, 4'b0000, 10, 1'b1, 1'b1, 32'h0};
    vecs[4] = '{32'h0000_2000, 1'b0, 32'h0,         4'b1111, 3'b000, 7,   32'hCAFE_F00D, 1'b0, 1, 4'b0100, 4'b0000, 10, 1'b0, 1'b0, 32'hCAFE_F00D};
    vecs[5] = '{32'h0000_1FFC, 1'b0, 32'h0,         4'b1111, 3'b000, 1,   32'h55AA_55AA, 1'b1, 5, 4'b0010, 4'b0000, 4,  1'b1, 1'b0, 32'h0};
    vecs[6] = '{32'h0000_2ABC, 1'b1, 32'h0F0F_0F0F, 4'b0101, 3'b100, 2,   32'h9999_9999, 1'b1, 0, 4'b0100, 4'b0101, 5,  1'b1, 1'b0, 32'h0};
    vecs[7] = '{32'h0000_0000, 1'b0, 32'h0,         4'b1111, 3'b101, 0,   32'h0000_0001, 1'b0, 0, 4'b0001, 4'b0000, 3,  1'b0, 1'b0, 32'h0000_0001};
    vecs[8] = '{32'hFFFF_FFF0, 1'b1, 32'h1234_0000, 4'b1111, 3'b000, 0,   32'h0,         1'b0, 0, 4'b0000, 4'b0000, 1,  1'b1, 1'b0, 32'h0};

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    req_strb = '0; req_prot = '0; rsp_ready = 1'b0; pready = '0; prdata = '0; pslverr = '0;
    step();
    step();
    check("reset_apb_zero", {psel, penable, pwrite, pstrb, pprot}, 0);
    check("reset_rsp_zero", {rsp_valid, req_ready, rsp_error, rsp_timeout}, 0);
    check("reset_paddr_zero", paddr, 0);
    check("reset_rdata_zero", rsp_rdata, 0);
    reset = 1'b0;
    step();
    check("ready_after_reset", req_ready, 1);

    for (int k = 0; k < 9; k++) run_vec(k);

    // Reset in the middle of a stalled ACCESS phase: transfer must vanish.
    cur_vec = 100;
    wait_ready();
    req_valid = 1'b1; req_addr = 32'h0000_3000; req_write = 1'b1;
    req_wdata = 32'hFEED_0000; req_strb = 4'b1100; req_prot = 3'b011;
    noise_lanes(3);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !penable; i++) begin
      noise_lanes(3);
      step();
    end
    check("rst_reached_access", penable, 1);
    noise_lanes(3);
    step();
    reset = 1'b1;
    noise_lanes(3);
    step();
    check("rst_apb_zero", {psel, penable, pwrite, pstrb, pprot}, 0);
    check("rst_rsp_zero", {rsp_valid, req_ready, rsp_error, rsp_timeout}, 0);
    check("rst_paddr_zero", paddr, 0);
    check("rst_pwdata_zero", pwdata, 0);
    check("rst_rdata_zero", rsp_rdata, 0);
    reset = 1'b0;
    step();
    check("rst_ready_after", req_ready, 1);
    bad = 0;
    repeat (15) begin
      noise_lanes(-1);
      if (rsp_valid || psel != 0 || penable) bad = 1;
      step();
    end
    check("rst_no_response", bad, 0);

    run_vec(0);
    run_vec(1);
    cur_vec = -1;
    check("scoreboard_empty", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_manager.md
# apb_manager

Parametrised APB manager that turns a valid/ready request stream into APB transfers across `PrphNum` peripherals. Adds address decoding, per-peripheral ready/read-data/error muxing, write strobes, protection pass-through and a wait-state timeout watchdog on top of the shared APB signal set. It sits between a system-side requester (core load/store unit or bus bridge) and the peripheral bank.

## Interface
Parameters:
- `AddrWidth`, 32: byte address width.
- `DataWidth`, 32: data width; one of 8, 16, 32 or 64.
- `PrphNum`, 4: number of peripherals, 1 to 16.
- `BaseAddr`, 32'h0: first byte address of peripheral 0.
- `RegionBits`, 12: each peripheral owns 2^RegionBits bytes, packed contiguously from `BaseAddr`.
- `TimeoutCycles`, 256: maximum ACCESS cycles before abort; 0 disables the watchdog.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset; one clock; reset is synchronous and active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted this cycle
- `req_addr`  in  AddrWidth  byte address
- `req_write`  in  1  1 = write, 0 = read
- `req_wdata`  in  DataWidth  write data
- `req_strb`  in  DataWidth/8  byte strobes
- `req_prot`  in  3  protection type
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed
- `rsp_rdata`  out  DataWidth  read data; 0 for writes and for errors
- `rsp_error`  out  1  slave error, decode error or timeout
- `rsp_timeout`  out  1  error was caused by the watchdog
- `paddr`  out  AddrWidth  APB address
- `pprot`  out  3  APB protection type
- `psel`  out  PrphNum  one-hot peripheral select
- `penable`  out  1  APB access phase
- `pwrite`  out  1  APB direction
- `pwdata`  out  DataWidth  APB write data
- `pstrb`  out  DataWidth/8  APB strobes
- `pready`  in  PrphNum  per-peripheral ready
- `prdata`  in  PrphNum*DataWidth  per-peripheral read data; lane i is bits [i*DataWidth +: DataWidth]
- `pslverr`  in  PrphNum  per-peripheral error

## Operation
- **States:** IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - `req_ready` = 1 only in this state.
  - On `req_valid`, register the address, direction, data, strobes and protection, and compute `idx = (req_addr - BaseAddr) >> RegionBits`.
  - If `req_addr < BaseAddr` or `idx >= PrphNum`, this is a decode error: go to RESP with `rsp_error`=1 and `rsp_timeout`=0. No `psel` is ever asserted.
  - Otherwise go to SETUP.
- **SETUP**
  - `psel[idx]` = 1 and `penable` = 0.
  - `paddr` carries the full address. `pwrite`, `pprot` and `pwdata` are driven from the registered request.
  - `pstrb` = `req_strb` on writes and is forced to 0 on reads.
  - Always advances to ACCESS after one cycle.
- **ACCESS**
  - `penable` = 1. All other APB outputs are identical to SETUP.
  - Waits for `pready[idx]`; ready, error and data lanes of unselected peripherals are ignored.
  - On `pready[idx]`:
    - capture `rsp_error = pslverr[idx]`;
    - capture `rsp_rdata = prdata` lane `idx` for a read with no error, otherwise 0;
    - go to RESP.
- **Watchdog**
  - Counts ACCESS cycles; the count is 1 in the first ACCESS cycle.
  - If the count reaches `TimeoutCycles` and `pready[idx]` is 0, go to RESP with `rsp_error`=1, `rsp_timeout`=1 and `rsp_rdata`=0.
  - If `pready[idx]` is 1 in that same cycle, ready wins.
  - The counter clears on entry to SETUP. Its width is `$clog2(TimeoutCycles+1)`.
- **RESP**
  - `psel`, `penable` and `pstrb` are all 0.
  - `rsp_valid` = 1, and the response fields are held stable until `rsp_ready`; then go to IDLE.
  - No new request is accepted in the cycle `rsp_ready` is seen.
- **Reset:** all outputs are 0 and the state is IDLE, including the outputs `psel`, `penable`, `rsp_valid` and `req_ready`. A reset in any state aborts the transfer at the next edge, and no response is produced.

## Timing
- The request handshake is in cycle 0 (`req_valid` & `req_ready`), SETUP is cycle 1 and ACCESS starts in cycle 2.
- With zero wait states, `pready` is sampled in cycle 2 and `rsp_valid` rises in cycle 3. Each wait state adds one cycle.
- Decode error: `rsp_valid` rises in cycle 1.
- Timeout: `rsp_valid` rises `TimeoutCycles` cycles after the first ACCESS cycle.
- Back-to-back throughput is one transfer every 4 cycles with zero wait states and immediate `rsp_ready`.
- All outputs are registered or decoded from registered state only; there are no combinational paths from `pready`, `prdata` or `pslverr` to any output.

## Structure
- Package `apb_pkg`:
  - `apb_state_e` enum (IDLE, SETUP, ACCESS, RESP);
  - `apb_prot_t` (3-bit: privileged, nonsecure, instruction);
  - a `clog2`-derived index width constant helper.
- Sub-module `apb_addr_decoder`: combinational; inputs are the address; outputs are `idx`, the one-hot select and `hit`. Parametrised by `BaseAddr`, `RegionBits` and `PrphNum`.

## Test plan
- Zero-wait write, `PrphNum`=4: write 0xDEADBEEF to 0x1004 with strb 4'b1111 → `psel`=4'b0010 in cycles 1–2, `penable` only in cycle 2, `pstrb`=4'hF, then `rsp_valid` in cycle 3 with `rsp_error`=0 and `rsp_rdata`=0.
- Read with 3 wait states from 0x3010, peripheral 3 returning 0x12345678 → `rsp_valid` in cycle 6, `rsp_rdata`=0x12345678. `pstrb`=0 throughout, and noise on the lanes of peripherals 0–2 has no effect.
- Decode error: access to 0x4000 (idx 4) → no `psel`, `rsp_valid` in cycle 1, `rsp_error`=1, `rsp_timeout`=0.
- Timeout with `TimeoutCycles`=8 and `pready` held low → exactly 8 ACCESS cycles, then `psel`/`penable` drop and the response has `rsp_error`=1, `rsp_timeout`=1. Separately, `pready` arriving in the 8th ACCESS cycle → normal response.
- Backpressure and slave error: `pslverr` asserted on a read while `rsp_ready` is held low for 5 cycles → response stable with `rsp_error`=1 and `rsp_rdata`=0, and `req_ready` stays 0 until one cycle after `rsp_ready`.
- Reset asserted in ACCESS → next cycle all outputs are 0 and `req_ready`=1 after reset deasserts; no `rsp_valid` is ever produced for the aborted transfer.
